// File: rtl/io_port_if.sv
// Bundle of the processor-facing and device-facing signals of the I/O port
// controller. The controller takes the slave view; whatever drives the
// processor/board side (top level or bench) takes the master view.
interface io_port_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dev_in_data;
  logic              dev_in_valid;
  logic              dev_in_ready;
  logic [DATA_W-1:0] in_port;
  logic              port_rd;
  logic              in_empty;
  logic [DATA_W-1:0] out_port;
  logic              port_wr;
  logic [DATA_W-1:0] dev_out_data;
  logic              dev_out_valid;
  logic              dev_out_ready;
  logic              out_overrun;
  logic              ext_irq;
  logic              rti_done;
  logic              interrupt;
  logic              irq_busy;

  modport master (
    output dev_in_data, dev_in_valid, port_rd, out_port, port_wr,
           dev_out_ready, ext_irq, rti_done,
    input  dev_in_ready, in_port, in_empty, dev_out_data, dev_out_valid,
           out_overrun, interrupt, irq_busy
  );

  modport slave (
    input  dev_in_data, dev_in_valid, port_rd, out_port, port_wr,
           dev_out_ready, ext_irq, rti_done,
    output dev_in_ready, in_port, in_empty, dev_out_data, dev_out_valid,
           out_overrun, interrupt, irq_busy
  );
endinterface

// File: rtl/io_port_controller.sv
// Device-side end of the processor I/O interface: input FIFO feeding the
// processor inputPort, a valid/ready capture register for OUT writes, and an
// interrupt request/RTI handshake driven from a synchronised external line.
module io_port_controller #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int IRQ_HOLD   = 2
) (
  input logic   clk,
  input logic   rst,
  io_port_if.slave bus
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSERT   = 2'd1;
  localparam logic [1:0] WAIT_RTI = 2'd2;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_last;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.port_rd && !w_empty;
  // A word offered while full is still taken when the head is popped in the
  // same cycle: the slot being freed is the one the write pointer targets.
  assign w_push  = bus.dev_in_valid && (!w_full || w_pop);

  assign bus.dev_in_ready = !w_full;
  assign bus.in_empty     = w_empty;
  assign bus.in_port      = w_empty ? r_last : r_mem[r_rd_ptr];

  // Storage array: data only, occupancy bookkeeping lives elsewhere
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.dev_in_data;
  end

  // Pointers, occupancy and the last-popped word shown once the FIFO drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------ output channel
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_overrun;

  assign bus.dev_out_data  = r_out_data;
  assign bus.dev_out_valid = r_out_valid;
  assign bus.out_overrun   = r_overrun;

  // Capture OUT writes; flag an overwrite of a word the device never took
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (bus.port_wr) begin
      r_out_data  <= bus.out_port;
      r_out_valid <= 1'b1;
      if (r_out_valid && !bus.dev_out_ready) r_overrun <= 1'b1;
    end else if (r_out_valid && bus.dev_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // ----------------------------------------------------------- interrupt
  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync_prev;
  logic              w_req;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              r_pending;
  logic              w_pending_nxt;
  logic              r_irq;
  logic              r_busy;

  assign w_req         = r_sync2 && !r_sync_prev;
  assign bus.interrupt = r_irq;
  assign bus.irq_busy  = r_busy;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= bus.ext_irq;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // Request/RTI FSM next state; requests arriving while busy merge into one
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_pending_nxt = r_pending;
    case (r_state)
      IDLE: begin
        if (w_req || r_pending) begin
          w_state_nxt   = ASSERT;
          w_hold_nxt    = HOLD_W'(IRQ_HOLD - 1);
          w_pending_nxt = 1'b0;
        end
      end
      ASSERT: begin
        if (w_req) w_pending_nxt = 1'b1;
        if (r_hold == '0) w_state_nxt = WAIT_RTI;
        else              w_hold_nxt  = r_hold - 1'b1;
      end
      WAIT_RTI: begin
        if (w_req) w_pending_nxt = 1'b1;
        if (bus.rti_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state with registered interrupt and busy outputs decoded from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_pending <= w_pending_nxt;
      r_irq     <= (w_state_nxt == ASSERT);
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: FIFO fill/drain, full push+pop,
// output overrun, interrupt timing, request merging and mid-operation reset.
module tb_io_port_controller;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  io_port_if #(.DATA_W(16)) bus ();

  io_port_controller #(
    .DATA_W(16), .FIFO_DEPTH(4), .IRQ_HOLD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d);
    bus.dev_in_data  = d;
    bus.dev_in_valid = 1'b1;
    tick();
    bus.dev_in_valid = 1'b0;
  endtask

  logic [15:0] exp_seq [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.dev_in_data = '0;  bus.dev_in_valid = 1'b0; bus.port_rd = 1'b0;
    bus.out_port = '0;     bus.port_wr = 1'b0;      bus.dev_out_ready = 1'b0;
    bus.ext_irq = 1'b0;    bus.rti_done = 1'b0;
    tick(2);
    rst = 1'b0;

    // reset state
    check("rst_empty",   bus.in_empty, 1);
    check("rst_in_port", bus.in_port, 0);
    check("rst_ready",   bus.dev_in_ready, 1);
    check("rst_ovalid",  bus.dev_out_valid, 0);
    check("rst_odata",   bus.dev_out_data, 0);
    check("rst_overrun", bus.out_overrun, 0);
    check("rst_irq",     bus.interrupt, 0);
    check("rst_busy",    bus.irq_busy, 0);

    // test 1: fill and drain
    push(16'h1111);
    check("t1_first_visible", bus.in_port, 16'h1111);
    push(16'h2222); push(16'h3333); push(16'h4444);
    check("t1_full_ready", bus.dev_in_ready, 0);
    check("t1_head", bus.in_port, 16'h1111);
    exp_seq[0] = 16'h2222; exp_seq[1] = 16'h3333; exp_seq[2] = 16'h4444; exp_seq[3] = 16'h4444;
    bus.port_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t1_pop%0d", i), bus.in_port, exp_seq[i]);
    end
    check("t1_empty", bus.in_empty, 1);
    tick();  // read while empty: ignored
    bus.port_rd = 1'b0;
    check("t1_rd_empty_port", bus.in_port, 16'h4444);
    check("t1_rd_empty_flag", bus.in_empty, 1);
    check("t1_rd_empty_ready", bus.dev_in_ready, 1);

    // test 2: push and pop together while full
    push(16'h0A01); push(16'h0A02); push(16'h0A03); push(16'h0A04);
    bus.dev_in_data = 16'h5555; bus.dev_in_valid = 1'b1; bus.port_rd = 1'b1;
    tick();
    bus.dev_in_valid = 1'b0;
    check("t2_still_full", bus.dev_in_ready, 0);
    check("t2_head", bus.in_port, 16'h0A02);
    exp_seq[0] = 16'h0A03; exp_seq[1] = 16'h0A04; exp_seq[2] = 16'h5555; exp_seq[3] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t2_pop%0d", i), bus.in_port, exp_seq[i]);
    end
    bus.port_rd = 1'b0;
    check("t2_empty", bus.in_empty, 1);

    // test 3: output overrun
    bus.out_port = 16'hABCD; bus.port_wr = 1'b1; bus.dev_out_ready = 1'b0;
    tick();
    bus.port_wr = 1'b0;
    check("t3_valid1", bus.dev_out_valid, 1);
    check("t3_data1", bus.dev_out_data, 16'hABCD);
    check("t3_no_overrun", bus.out_overrun, 0);
    bus.out_port = 16'h1234; bus.port_wr = 1'b1;
    tick();
    bus.port_wr = 1'b0;
    check("t3_data2", bus.dev_out_data, 16'h1234);
    check("t3_overrun", bus.out_overrun, 1);
    check("t3_valid2", bus.dev_out_valid, 1);
    bus.dev_out_ready = 1'b1;
    tick();
    bus.dev_out_ready = 1'b0;
    check("t3_accept", bus.dev_out_valid, 0);
    check("t3_sticky", bus.out_overrun, 1);

    // test 4: interrupt timing
    bus.ext_irq = 1'b1;
    tick(); check("t4_c1", bus.interrupt, 0);
    tick(); check("t4_c2", bus.interrupt, 0);
    tick(); check("t4_c3", bus.interrupt, 1); check("t4_busy3", bus.irq_busy, 1);
    tick(); check("t4_c4", bus.interrupt, 1);
    tick(); check("t4_c5", bus.interrupt, 0); check("t4_busy5", bus.irq_busy, 1);
    bus.ext_irq = 1'b0;
    tick(3);
    check("t4_wait_busy", bus.irq_busy, 1);
    check("t4_wait_irq", bus.interrupt, 0);
    bus.rti_done = 1'b1;
    tick();
    bus.rti_done = 1'b0;
    check("t4_idle_busy", bus.irq_busy, 0);

    // test 5: two requests during WAIT_RTI merge into one
    bus.ext_irq = 1'b1;
    tick(5);
    check("t5_in_wait", bus.irq_busy, 1);
    bus.ext_irq = 1'b0; tick(3);
    bus.ext_irq = 1'b1; tick(3);
    bus.ext_irq = 1'b0; tick(3);
    bus.ext_irq = 1'b1; tick(3);
    check("t5_wait_irq", bus.interrupt, 0);
    bus.rti_done = 1'b1;
    tick();
    bus.rti_done = 1'b0;
    check("t5_rti_irq", bus.interrupt, 0);
    check("t5_rti_busy", bus.irq_busy, 0);
    tick(); check("t5_p1", bus.interrupt, 1);
    tick(); check("t5_p2", bus.interrupt, 1);
    tick(); check("t5_p3", bus.interrupt, 0); check("t5_p3_busy", bus.irq_busy, 1);
    bus.rti_done = 1'b1;
    tick();
    bus.rti_done = 1'b0;
    tick(4);
    check("t5_no_second_irq", bus.interrupt, 0);
    check("t5_no_second_busy", bus.irq_busy, 0);

    // test 6: reset while asserting, FIFO holding two words, output pending
    bus.ext_irq = 1'b0;
    push(16'h0B01); push(16'h0B02);
    bus.out_port = 16'h7777; bus.port_wr = 1'b1;
    tick();
    bus.port_wr = 1'b0;
    tick(2);
    bus.ext_irq = 1'b1;
    tick(3);
    check("t6_pre_irq", bus.interrupt, 1);
    check("t6_pre_empty", bus.in_empty, 0);
    rst = 1'b1; bus.ext_irq = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_irq", bus.interrupt, 0);
    check("t6_empty", bus.in_empty, 1);
    check("t6_in_port", bus.in_port, 0);
    check("t6_ovalid", bus.dev_out_valid, 0);
    check("t6_busy", bus.irq_busy, 0);
    check("t6_overrun", bus.out_overrun, 0);

    // write while pending and accepted the same cycle: no overrun
    bus.out_port = 16'h1111; bus.port_wr = 1'b1;
    tick();
    bus.out_port = 16'h2222; bus.dev_out_ready = 1'b1;
    tick();
    bus.port_wr = 1'b0; bus.dev_out_ready = 1'b0;
    check("t7_data", bus.dev_out_data, 16'h2222);
    check("t7_valid", bus.dev_out_valid, 1);
    check("t7_no_overrun", bus.out_overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
